// File: rtl/uart_tx_framer_if.sv
// uart_tx_framer_if: message handshake (valid/ready plus opt, len, data) into uart_tx_framer.
interface uart_tx_framer_if #(
    parameter int BYTE_SIZE  = 8,
    parameter int DATA_BYTES = 8
);
    logic                            i_valid;
    logic                            o_ready;
    logic [BYTE_SIZE-1:0]            i_opt;
    logic [BYTE_SIZE-1:0]            i_len;
    logic [DATA_BYTES*BYTE_SIZE-1:0] i_data;
    modport master (output i_valid, i_opt, i_len, i_data, input o_ready);
    modport slave  (input i_valid, i_opt, i_len, i_data, output o_ready);
endinterface

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises init pattern, opt, len, data and CRC-32 onto o_bit.
// Define UART_TX_STOP_BIT_EN to follow every byte with a 1 stop bit.
module uart_tx_framer #(
    parameter int         BYTE_SIZE    = 8,
    parameter int         DATA_BYTES   = 8,
    parameter int         CLKS_PER_BIT = 1,
    parameter logic [6:0] INIT_PATTERN = 7'h7e
) (
    input  logic            CLK,
    input  logic            RST_N,
    uart_tx_framer_if.slave s,
    output logic            o_bit,
    output logic            o_busy,
    output logic            o_done
);
    localparam int DW = DATA_BYTES * BYTE_SIZE;
`ifdef UART_TX_STOP_BIT_EN
    localparam int BLEN = BYTE_SIZE + 2;
`else
    localparam int BLEN = BYTE_SIZE + 1;
`endif
    localparam int PW = $clog2(BLEN + 1);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    typedef enum logic [2:0] {IDLE, INIT, OPT, LEN, DATA, CSM} state_t;
    state_t st, nxt;
    logic [CW-1:0] clk_cnt;
    logic [PW-1:0] pos;
    logic [BYTE_SIZE-1:0] byte_cnt, opt_q, len_q, len_c, cur, sel;
    logic [DW-1:0] data_q;
    logic [31:0] crc;
    logic [6:0] ini;
    logic acc, wrap, last, end_bit, dbit, crc_en;
    assign acc = s.i_valid && s.o_ready;
    assign s.o_ready = st == IDLE;
    assign o_busy = st != IDLE;
    assign len_c = s.i_len > BYTE_SIZE'(DATA_BYTES) ? BYTE_SIZE'(DATA_BYTES) : s.i_len;
    assign wrap = clk_cnt == CW'(CLKS_PER_BIT - 1);
    assign last = st == INIT ? pos == PW'(6) : pos == PW'(BLEN - 1);
    assign end_bit = wrap && last;
    // pos 0 is the start bit, pos 1..BYTE_SIZE the data bits MSB first
    assign cur = st == OPT ? opt_q : st == LEN ? len_q : st == DATA ? data_q[DW-1 -: BYTE_SIZE] : crc[31 -: BYTE_SIZE];
    assign sel = cur << (pos - PW'(1));
    assign ini = INIT_PATTERN << pos;
    assign dbit = sel[BYTE_SIZE-1];
    assign crc_en = wrap && (st == OPT || st == LEN || st == DATA) && pos != '0 && pos <= PW'(BYTE_SIZE);
    assign o_bit = st == IDLE ? 1'b1 : st == INIT ? ini[6] : pos == '0 ? 1'b0 : pos > PW'(BYTE_SIZE) ? 1'b1 : dbit;
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) st <= IDLE;
        else st <= nxt;
    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = acc ? INIT : IDLE;
            INIT:    nxt = end_bit ? OPT : INIT;
            OPT:     nxt = end_bit ? LEN : OPT;
            LEN:     nxt = !end_bit ? LEN : len_q == '0 ? CSM : DATA;
            DATA:    nxt = end_bit && byte_cnt == len_q - BYTE_SIZE'(1) ? CSM : DATA;
            CSM:     nxt = end_bit && byte_cnt == BYTE_SIZE'(3) ? IDLE : CSM;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            clk_cnt  <= '0;
            pos      <= '0;
            byte_cnt <= '0;
            opt_q    <= '0;
            len_q    <= '0;
            data_q   <= '0;
            crc      <= '0;
            o_done   <= 1'b0;
        end else begin
            o_done <= st == CSM && nxt == IDLE;
            if (acc) begin
                opt_q    <= s.i_opt;
                len_q    <= len_c;
                data_q   <= s.i_data << (BYTE_SIZE * (DATA_BYTES - 32'(len_c)));
                crc      <= '1;
                clk_cnt  <= '0;
                pos      <= '0;
                byte_cnt <= '0;
            end else if (st != IDLE) begin
                clk_cnt <= wrap ? '0 : clk_cnt + CW'(1);
                if (wrap) pos <= last ? '0 : pos + PW'(1);
                if (crc_en) crc <= {crc[30:0], 1'b0} ^ (crc[31] ^ dbit ? POLY : '0);
                if (end_bit) begin
                    byte_cnt <= nxt != st ? '0 : byte_cnt + BYTE_SIZE'(1);
                    if (st == DATA) data_q <= data_q << BYTE_SIZE;
                    if (st == CSM) crc <= crc << BYTE_SIZE;
                end
            end
        end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: table of frames on a CLKS_PER_BIT=1 instance, async reset sequence,
// and a back-to-back sequence on a CLKS_PER_BIT=4 instance.
module tb_uart_tx_framer;
`ifdef UART_TX_STOP_BIT_EN
    localparam int BL = 10;
`else
    localparam int BL = 9;
`endif
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic bit1, busy1, done1, bit4, busy4, done4;
    uart_tx_framer_if #(.BYTE_SIZE(8), .DATA_BYTES(8)) b1 ();
    uart_tx_framer_if #(.BYTE_SIZE(8), .DATA_BYTES(8)) b4 ();
    uart_tx_framer #(.CLKS_PER_BIT(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .s(b1), .o_bit(bit1), .o_busy(busy1), .o_done(done1));
    uart_tx_framer #(.CLKS_PER_BIT(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .s(b4), .o_bit(bit4), .o_busy(busy4), .o_done(done4));
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  opt;
        logic [7:0]  len;
        logic [63:0] data;
        logic [7:0]  len_w;
        int          nbits;
    } vec_t;
    vec_t vecs[6];
    int checks = 0;
    int errors = 0;
    logic exp_q[$];
    logic got_q[$];
    logic [31:0] crc_m, crc_f;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? 32'h04C11DB7 : 32'h0);
    endfunction

    task automatic put_byte(input logic [7:0] v, input logic upd);
        exp_q.push_back(1'b0);
        for (int k = 7; k >= 0; k--) begin
            exp_q.push_back(v[k]);
            if (upd) crc_m = crc_step(crc_m, v[k]);
        end
`ifdef UART_TX_STOP_BIT_EN
        exp_q.push_back(1'b1);
`endif
    endtask

    task automatic build(input logic [7:0] opt, input logic [7:0] len, input logic [63:0] data);
        logic [6:0] ip;
        logic [7:0] lc;
        ip = 7'h7e;
        exp_q.delete();
        crc_m = 32'hFFFFFFFF;
        for (int k = 6; k >= 0; k--) exp_q.push_back(ip[k]);
        lc = len > 8'd8 ? 8'd8 : len;
        put_byte(opt, 1'b1);
        put_byte(lc, 1'b1);
        for (int k = int'(lc) - 1; k >= 0; k--) put_byte(data[k*8 +: 8], 1'b1);
        crc_f = crc_m;
        for (int j = 0; j < 4; j++) put_byte(crc_f[31-8*j -: 8], 1'b0);
    endtask

    task automatic run_frame(input vec_t v, input int i);
        int n, bad, base, ln;
        logic hs;
        logic [7:0] lb;
        logic [31:0] cw;
        logic [46:0] lit;
        build(v.opt, v.len, v.data);
        @(negedge CLK);
        b1.i_valid = 1'b1;
        b1.i_opt = v.opt;
        b1.i_len = v.len;
        b1.i_data = v.data;
        chk($sformatf("ready_idle[%0d]", i), 64'(b1.o_ready), 64'(1));
        @(posedge CLK);
        #1;
        b1.i_valid = 1'b0;
        b1.i_opt = 8'($urandom);
        b1.i_len = 8'($urandom);
        b1.i_data = {$urandom, $urandom};
        got_q.delete();
        n = 0;
        bad = 0;
        hs = 1'b0;
        while (!hs && n < 400) begin
            @(negedge CLK);
            if (done1) hs = 1'b1;
            else begin
                got_q.push_back(bit1);
                if (b1.o_ready || !busy1) bad++;
            end
            n++;
        end
        chk($sformatf("done_seen[%0d]", i), 64'(hs), 64'(1));
        chk($sformatf("ready_at_done[%0d]", i), 64'(b1.o_ready), 64'(1));
        chk($sformatf("busy_ready_in_frame[%0d]", i), 64'(bad), 64'(0));
        chk($sformatf("frame_bits[%0d]", i), 64'(got_q.size()), 64'(v.nbits));
        bad = 0;
        foreach (exp_q[k]) if (k >= got_q.size() || got_q[k] !== exp_q[k]) bad++;
        chk($sformatf("bit_stream[%0d]", i), 64'(bad), 64'(0));
        lb = 'x;
        if (got_q.size() >= 7 + 2 * BL) for (int k = 0; k < 8; k++) lb[7-k] = got_q[7 + BL + 1 + k];
        chk($sformatf("len_byte[%0d]", i), 64'(lb), 64'(v.len_w));
        cw = 'x;
        base = 7 + (2 + int'(v.len_w)) * BL;
        if (got_q.size() >= base + 4 * BL)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 8; k++) cw[31-8*j-k] = got_q[base + j*BL + 1 + k];
        chk($sformatf("crc[%0d]", i), 64'(cw), 64'(crc_f));
        if (i == 0) begin
`ifdef UART_TX_STOP_BIT_EN
            lit = 47'b1111110_0101001011_0000000101_0000100101_0001101001;
            ln = 47;
`else
            lit = 47'(43'b1111110_010100101_000000010_000010010_000110100);
            ln = 43;
`endif
            bad = 0;
            for (int k = 0; k < ln; k++) if (k >= got_q.size() || got_q[k] !== lit[ln-1-k]) bad++;
            chk("hand_prefix_a5_0212_34", 64'(bad), 64'(0));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        int sel[3];
        vec_t m;
        b1.i_valid = 1'b0;
        b1.i_opt = '0;
        b1.i_len = '0;
        b1.i_data = '0;
        b4.i_valid = 1'b0;
        b4.i_opt = '0;
        b4.i_len = '0;
        b4.i_data = '0;
        vecs[0] = '{8'hA5, 8'h02, 64'h1234, 8'h02, 7 + 8 * BL};
        vecs[1] = '{8'h01, 8'h00, 64'hDEAD, 8'h00, 7 + 6 * BL};
        vecs[2] = '{8'hC3, 8'h20, 64'h0123456789ABCDEF, 8'h08, 7 + 14 * BL};
        vecs[3] = '{8'h5A, 8'h08, 64'hFEDCBA9876543210, 8'h08, 7 + 14 * BL};
        vecs[4] = '{8'h00, 8'h01, 64'hFFFF_FFFF_FFFF_FF80, 8'h01, 7 + 7 * BL};
        vecs[5] = '{8'hFF, 8'h09, 64'h1122334455667788, 8'h08, 7 + 14 * BL};
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge CLK);
            if (bit1 !== 1'b1 || b1.o_ready !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 ||
                bit4 !== 1'b1 || b4.o_ready !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) bad++;
        end
        chk("idle_after_reset", 64'(bad), 64'(0));
        foreach (vecs[i]) run_frame(vecs[i], i);
        // abort a frame during the OPT start bit
        @(negedge CLK);
        b1.i_valid = 1'b1;
        b1.i_opt = 8'hA5;
        b1.i_len = 8'h02;
        b1.i_data = 64'h1234;
        @(posedge CLK);
        #1;
        b1.i_valid = 1'b0;
        repeat (8) @(negedge CLK);
        chk("pre_reset_bit", 64'(bit1), 64'(0));
        chk("pre_reset_busy", 64'(busy1), 64'(1));
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_reset_bit", 64'(bit1), 64'(1));
        chk("async_reset_busy", 64'(busy1), 64'(0));
        chk("async_reset_ready", 64'(b1.o_ready), 64'(1));
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        chk("post_reset_ready", 64'(b1.o_ready), 64'(1));
        chk("post_reset_bit", 64'(bit1), 64'(1));
        // three frames with i_valid held high, CLKS_PER_BIT=4
        sel = '{0, 1, 3};
        @(negedge CLK);
        m = vecs[sel[0]];
        b4.i_valid = 1'b1;
        b4.i_opt = m.opt;
        b4.i_len = m.len;
        b4.i_data = m.data;
        for (int f = 0; f < 3; f++) begin
            m = vecs[sel[f]];
            build(m.opt, m.len, m.data);
            chk($sformatf("b2b_ready[%0d]", f), 64'(b4.o_ready), 64'(1));
            @(posedge CLK);
            #1;
            if (f < 2) begin
                b4.i_opt = vecs[sel[f+1]].opt;
                b4.i_len = vecs[sel[f+1]].len;
                b4.i_data = vecs[sel[f+1]].data;
            end else b4.i_valid = 1'b0;
            bad = 0;
            for (int c = 0; c < exp_q.size() * 4; c++) begin
                @(negedge CLK);
                if (bit4 !== exp_q[c/4] || done4 !== 1'b0 || b4.o_ready !== 1'b0) bad++;
            end
            chk($sformatf("b2b_stream[%0d]", f), 64'(bad), 64'(0));
            @(negedge CLK);
            chk($sformatf("b2b_done[%0d]", f), 64'(done4), 64'(1));
        end
        @(negedge CLK);
        chk("b2b_idle_after", 64'(busy4), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
